// File: rtl/mhz1_bus_bridge.sv
// Bridge that stretches CPU accesses to 1 MHz peripherals and runs them aligned to the 1 MHz enable.
// Optional feature macro: MHZ1_BUS_EXT_EN (pages &FC FRED and &FD JIM also decode as slow).
module mhz1_bus_bridge #(
    parameter logic [7:0] FE_SLOW_MAP = 8'b00001101,
    parameter logic [7:0] RDATA_RESET = 8'hFF
) (
    input  logic        clk_32m,
    input  logic        reset,
    input  logic        cpu_clken,
    input  logic        mhz1_clken,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic        cpu_vma,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  per_din,
    output logic        mhz1_enable,
    output logic        per_cs,
    output logic [7:0]  per_addr,
    output logic [1:0]  per_page,
    output logic        per_rnw,
    output logic [7:0]  per_wdata,
    output logic        per_strobe,
    output logic [7:0]  cpu_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic        r_req_q;
    logic        r_mhz1_enable;
    logic        r_per_cs;
    logic [7:0]  r_per_addr;
    logic [1:0]  r_per_page;
    logic        r_per_rnw;
    logic [7:0]  r_per_wdata;
    logic [7:0]  r_cpu_rdata;
    logic        r_busy;

    logic [7:0]  w_hi;
    logic        w_slow;
    logic [1:0]  w_page;

    // NOTE: every decode output gets a default before any condition, so no latch is inferred.
    always_comb begin
        w_hi   = cpu_addr[15:8];
        w_slow = 1'b0;
        w_page = 2'd2;
        if (w_hi == 8'hFE && FE_SLOW_MAP[cpu_addr[7:5]]) begin
            w_slow = 1'b1;
        end
`ifdef MHZ1_BUS_EXT_EN
        if (w_hi == 8'hFC) begin
            w_slow = 1'b1;
            w_page = 2'd0;
        end
        if (w_hi == 8'hFD) begin
            w_slow = 1'b1;
            w_page = 2'd1;
        end
`else
        w_page = 2'd2;
`endif
        w_slow = w_slow & cpu_vma;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_32m) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_q       <= 1'b0;
            r_mhz1_enable <= 1'b0;
            r_per_cs      <= 1'b0;
            r_per_addr    <= 8'h00;
            r_per_page    <= 2'd0;
            r_per_rnw     <= 1'b0;
            r_per_wdata   <= 8'h00;
            r_cpu_rdata   <= RDATA_RESET;
            r_busy        <= 1'b0;
        end else begin
            r_req_q <= cpu_clken;
            case (r_state)
                ST_IDLE: begin
                    // Entering ARMED even on a mhz1_clken cycle defers ACCESS to the next 1 MHz edge.
                    if (r_req_q && w_slow) begin
                        r_per_addr    <= cpu_addr[7:0];
                        r_per_page    <= w_page;
                        r_per_rnw     <= cpu_rnw;
                        r_per_wdata   <= cpu_wdata;
                        r_mhz1_enable <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (mhz1_clken) begin
                        r_per_cs <= 1'b1;
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mhz1_clken) begin
                        if (r_per_rnw) begin
                            r_cpu_rdata <= per_din;
                        end
                        r_per_cs      <= 1'b0;
                        r_mhz1_enable <= 1'b0;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so an abandoned access never commits.
    assign per_strobe  = (r_state == ST_ACCESS) & mhz1_clken & ~reset;

    assign mhz1_enable = r_mhz1_enable;
    assign per_cs      = r_per_cs;
    assign per_addr    = r_per_addr;
    assign per_page    = r_per_page;
    assign per_rnw     = r_per_rnw;
    assign per_wdata   = r_per_wdata;
    assign cpu_rdata   = r_cpu_rdata;
    assign busy        = r_busy;

endmodule
